// File: rtl/layer_pulse_gen.sv
// Per-layer shot sequencer: fires the enabled channels after a programmable delay,
// then either re-arms on the delay timer or waits for channel feedback.
module layer_pulse_gen #(
   parameter int DLY_W = 16
) (
   input  logic             io_clk,
   input  logic             io_rst,
   input  logic             io_start,
   input  logic             io_stop,
   input  logic [7:0]       io_layerCfg,
   input  logic             io_workingMode,
   input  logic [DLY_W-1:0] io_delayCycles,
   input  logic [DLY_W-1:0] io_fbTimeout,
   input  logic [7:0]       io_fbCatch,
   input  logic             io_layerEnd,
   output logic [7:0]       io_switchEnLogic,
   output logic [7:0]       io_delayEnd,
   output logic             io_busy,
   output logic             io_done,
   output logic             io_timeoutErr,
   output logic [15:0]      io_shotCnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DELAY   = 3'd1,
      FIRE    = 3'd2,
      WAIT_FB = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cfg_q, cfg_d;
   logic             mode_q, mode_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [DLY_W-1:0] tmo_q, tmo_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;
   logic [15:0]      shotCnt_q, shotCnt_d;
   logic             err_q, err_d;
   logic             caught;

   // Feedback on channels that are not enabled for this layer is ignored.
   assign caught = |(io_fbCatch & cfg_q);

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      mode_d    = mode_q;
      dly_d     = dly_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;
      shotCnt_d = shotCnt_q;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (io_start && !io_stop) begin
               cfg_d     = io_layerCfg;
               mode_d    = io_workingMode;
               dly_d     = io_delayCycles;
               tmo_d     = io_fbTimeout;
               cnt_d     = io_delayCycles;
               shotCnt_d = '0;
               err_d     = 1'b0;
               state_d   = (io_layerCfg == 8'h00) ? DONE : DELAY;
            end
         end
         DELAY: begin
            if (cnt_q == '0) state_d = FIRE;
            else             cnt_d   = cnt_q - DLY_W'(1);
         end
         FIRE: begin
            if (shotCnt_q != 16'hFFFF) shotCnt_d = shotCnt_q + 16'd1;
            if (mode_q) begin
               state_d = io_layerEnd ? DONE : DELAY;
               cnt_d   = dly_q;
            end else begin
               state_d = WAIT_FB;
               cnt_d   = tmo_q;
            end
         end
         WAIT_FB: begin
            // A catch on the expiry cycle still counts as a valid catch.
            if (caught) begin
               state_d = io_layerEnd ? DONE : DELAY;
               cnt_d   = dly_q;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (io_stop && (state_q inside {DELAY, FIRE, WAIT_FB})) begin
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = err_q;
      end
   end

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         mode_q    <= 1'b0;
         dly_q     <= '0;
         tmo_q     <= '0;
         cnt_q     <= '0;
         shotCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         mode_q    <= mode_d;
         dly_q     <= dly_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         shotCnt_q <= shotCnt_d;
         err_q     <= err_d;
      end
   end

   assign io_switchEnLogic = (state_q == FIRE) ? cfg_q : 8'h00;
   assign io_delayEnd      = ((state_q == FIRE) && mode_q) ? cfg_q : 8'h00;
   assign io_busy          = (state_q != IDLE);
   assign io_done          = (state_q == DONE);
   assign io_timeoutErr    = err_q;
   assign io_shotCnt       = shotCnt_q;

endmodule

// File: tb/tb_layer_pulse_gen.sv
// Scoreboard bench for layer_pulse_gen: a timeline model predicts every shot/done
// pulse per sequence; a monitor pops and compares whenever the DUT shows one.
module tb_layer_pulse_gen;

   logic        io_clk = 1'b0;
   logic        io_rst = 1'b1;
   logic        io_start = 1'b0;
   logic        io_stop = 1'b0;
   logic [7:0]  io_layerCfg = '0;
   logic        io_workingMode = 1'b0;
   logic [15:0] io_delayCycles = '0;
   logic [15:0] io_fbTimeout = '0;
   logic [7:0]  io_fbCatch = '0;
   logic        io_layerEnd = 1'b0;
   logic [7:0]  io_switchEnLogic;
   logic [7:0]  io_delayEnd;
   logic        io_busy;
   logic        io_done;
   logic        io_timeoutErr;
   logic [15:0] io_shotCnt;

   layer_pulse_gen #(.DLY_W(16)) dut (
      .io_clk(io_clk), .io_rst(io_rst), .io_start(io_start), .io_stop(io_stop),
      .io_layerCfg(io_layerCfg), .io_workingMode(io_workingMode),
      .io_delayCycles(io_delayCycles), .io_fbTimeout(io_fbTimeout),
      .io_fbCatch(io_fbCatch), .io_layerEnd(io_layerEnd),
      .io_switchEnLogic(io_switchEnLogic), .io_delayEnd(io_delayEnd),
      .io_busy(io_busy), .io_done(io_done), .io_timeoutErr(io_timeoutErr),
      .io_shotCnt(io_shotCnt)
   );

   always #5 io_clk = ~io_clk;

   typedef struct {
      int          cyc;
      bit          isDone;
      logic [7:0]  sw;
      logic [7:0]  de;
      logic [15:0] cnt;
      logic        err;
   } evt_t;

   evt_t       expQ[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic       leSched[0:255];
   logic [7:0] fbSched[0:255];

   always @(posedge io_clk) cyc <= cyc + 1;

   // Monitor: any visible pulse must match the oldest predicted event exactly.
   always @(negedge io_clk) begin
      evt_t ev;
      bit   ok;
      if (!io_rst && (io_switchEnLogic != 8'h00 || io_delayEnd != 8'h00 || io_done)) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_pulse cyc=%0d sw=%h de=%h done=%b required=no pulse",
                     cyc, io_switchEnLogic, io_delayEnd, io_done);
         end else begin
            ev = expQ.pop_front();
            ok = (cyc == ev.cyc) && (io_done == ev.isDone) && (io_switchEnLogic == ev.sw) &&
                 (io_delayEnd == ev.de) &&
                 (!ev.isDone || (io_shotCnt == ev.cnt && io_timeoutErr == ev.err));
            if (!ok) begin
               failures++;
               $display("[TB] FAIL pulse_event actual cyc=%0d done=%b sw=%h de=%h cnt=%0d err=%b required cyc=%0d done=%b sw=%h de=%h cnt=%0d err=%b",
                        cyc, io_done, io_switchEnLogic, io_delayEnd, io_shotCnt, io_timeoutErr,
                        ev.cyc, ev.isDone, ev.sw, ev.de, ev.cnt, ev.err);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic checkQueueDrained(input string name);
      checkOutput(name, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   // Builds the expected timeline from the sequence rules, then replays it cycle by cycle.
   // stopSel: 0 none, 1 random cycle, 2 first feedback-wait cycle.
   task automatic applyStimulus(input bit mode, input logic [7:0] cfg, input int dly, input int tmo,
                                input int nShots, input bit forceTo, input int fixLat, input int stopSel);
      evt_t       loc[$];
      evt_t       ev;
      int         t, f, c, lat, doneAt, lastCyc, stopAt, shots, base, firstFire;
      bit         fin;
      logic       errExp;
      logic [7:0] bitm;

      for (int i = 0; i < 256; i++) begin
         leSched[i] = 1'($urandom_range(0, 1));
         fbSched[i] = 8'($urandom) & ~cfg;
      end
      errExp = 1'b0;
      firstFire = dly + 2;
      if (cfg == 8'h00) begin
         doneAt = 1;
      end else begin
         t = 1;
         fin = 1'b0;
         doneAt = 0;
         for (int k = 1; !fin; k++) begin
            f = t + dly + 1;
            loc.push_back('{cyc: f, isDone: 1'b0, sw: cfg, de: mode ? cfg : 8'h00, cnt: 16'd0, err: 1'b0});
            if (mode) begin
               leSched[f] = (k == nShots);
               if (k == nShots) begin doneAt = f + 1; fin = 1'b1; end
               else t = f + 1;
            end else if (forceTo && k == nShots) begin
               doneAt = f + tmo + 2;
               errExp = 1'b1;
               fin = 1'b1;
            end else begin
               lat = (fixLat > 0) ? fixLat : $urandom_range(1, tmo + 1);
               c = f + lat;
               do bitm = 8'(1 << $urandom_range(0, 7)); while ((bitm & cfg) == 8'h00);
               fbSched[c] = fbSched[c] | bitm;
               leSched[c] = (k == nShots);
               if (k == nShots) begin doneAt = c + 1; fin = 1'b1; end
               else t = c + 1;
            end
         end
      end

      stopAt = -1;
      if (stopSel == 1 && doneAt > 1) stopAt = $urandom_range(1, doneAt - 1);
      else if (stopSel == 2)          stopAt = firstFire + 1;
      lastCyc = (stopAt >= 0) ? stopAt : doneAt;
      if (stopAt >= 0) errExp = 1'b0;
      shots = 0;
      foreach (loc[i]) if (loc[i].cyc <= lastCyc) shots++;
      if (doneAt <= lastCyc)
         loc.push_back('{cyc: doneAt, isDone: 1'b1, sw: 8'h00, de: 8'h00, cnt: 16'(shots), err: errExp});

      @(posedge io_clk); #1;
      base = cyc;
      foreach (loc[i]) if (loc[i].cyc <= lastCyc) begin
         ev = loc[i];
         ev.cyc += base;
         expQ.push_back(ev);
      end

      for (int r = 0; r <= lastCyc; r++) begin
         if (r > 0) begin @(posedge io_clk); #1; end
         if (r == 0) begin
            io_start = 1'b1; io_layerCfg = cfg; io_workingMode = mode;
            io_delayCycles = 16'(dly); io_fbTimeout = 16'(tmo);
         end else begin
            io_start = ($urandom_range(0, 3) == 0);
            io_layerCfg = 8'($urandom); io_workingMode = 1'($urandom_range(0, 1));
            io_delayCycles = 16'($urandom_range(0, 40)); io_fbTimeout = 16'($urandom_range(0, 40));
         end
         io_stop = (r == stopAt);
         io_layerEnd = leSched[r];
         io_fbCatch = fbSched[r];
         if (r == 1) begin
            @(negedge io_clk);
            checkOutput("busy_after_start", 32'(io_busy), 32'd1);
         end
      end

      @(posedge io_clk); #1;
      io_start = 1'b0; io_stop = 1'b0; io_layerEnd = 1'b0; io_fbCatch = 8'h00;
      repeat (2) @(posedge io_clk);
      @(negedge io_clk);
      checkOutput("busy_after_end", 32'(io_busy), 32'd0);
      checkOutput("shotCnt_final", 32'(io_shotCnt), 32'(shots));
      checkOutput("timeoutErr_final", 32'(io_timeoutErr), 32'(errExp));
      checkQueueDrained("events_left");
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_sw"},      32'(io_switchEnLogic), 32'd0);
      checkOutput({tag, "_de"},      32'(io_delayEnd), 32'd0);
      checkOutput({tag, "_busy"},    32'(io_busy), 32'd0);
      checkOutput({tag, "_done"},    32'(io_done), 32'd0);
      checkOutput({tag, "_err"},     32'(io_timeoutErr), 32'd0);
      checkOutput({tag, "_shotCnt"}, 32'(io_shotCnt), 32'd0);
   endtask

   initial begin
      int base;
      @(negedge io_clk);
      checkAllZero("reset");
      @(posedge io_clk); #1;
      io_rst = 1'b0;

      applyStimulus(1'b1, 8'h05, 3, 0, 3, 1'b0, 0, 0);
      applyStimulus(1'b0, 8'h81, 2, 5, 2, 1'b0, 2, 0);
      applyStimulus(1'b0, 8'h5A, 1, 10, 1, 1'b1, 0, 0);

      // Reset while idle must clear the sticky error and the shot count.
      @(posedge io_clk); #1;
      io_rst = 1'b1;
      @(negedge io_clk);
      checkAllZero("rst_idle");
      @(posedge io_clk); #1;
      io_rst = 1'b0;

      applyStimulus(1'b1, 8'h00, 4, 4, 1, 1'b0, 0, 0);
      applyStimulus(1'b0, 8'h81, 2, 6, 3, 1'b0, 2, 2);
      applyStimulus(1'b0, 8'h24, 1, 3, 2, 1'b0, 4, 0);
      applyStimulus(1'b1, 8'hC3, 0, 0, 8, 1'b0, 0, 0);

      // Reset in the second delay period after one shot.
      @(posedge io_clk); #1;
      base = cyc;
      expQ.push_back('{cyc: base + 8, isDone: 1'b0, sw: 8'h3C, de: 8'h3C, cnt: 16'd0, err: 1'b0});
      io_start = 1'b1; io_layerCfg = 8'h3C; io_workingMode = 1'b1; io_delayCycles = 16'd6;
      io_layerEnd = 1'b0;
      for (int r = 1; r <= 11; r++) begin
         @(posedge io_clk); #1;
         io_start = 1'b0;
      end
      io_rst = 1'b1;
      @(negedge io_clk);
      checkAllZero("rst_mid_delay");
      @(posedge io_clk); #1;
      io_rst = 1'b0;
      repeat (3) @(posedge io_clk);
      @(negedge io_clk);
      checkOutput("idle_after_rst", 32'(io_busy), 32'd0);
      checkQueueDrained("events_left_rst");

      // Stop beats start while idle; a launched sequence would fire two cycles later.
      @(posedge io_clk); #1;
      io_start = 1'b1; io_stop = 1'b1; io_layerCfg = 8'hFF; io_workingMode = 1'b1; io_delayCycles = 16'd0;
      @(posedge io_clk); #1;
      io_start = 1'b0; io_stop = 1'b0;
      @(negedge io_clk);
      checkOutput("stop_beats_start", 32'(io_busy), 32'd0);
      repeat (3) @(posedge io_clk);

      for (int n = 0; n < 30; n++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         applyStimulus(m, 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 8), $urandom_range(1, 4),
                       !m && ($urandom_range(0, 3) == 0), 0, ($urandom_range(0, 4) == 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
